// File: rtl/spi_arbiter.sv
// Three-requester round-robin arbiter in front of a single SPI byte engine.
// Owns chip select timing (setup, hold, inter-transaction gap) and per-byte handshakes.
module spi_arbiter #(
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [5:0]  req_len,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  byte_ack,
  output logic [7:0]  rdata,
  output logic [2:0]  txn_done,
  output logic        cs,
  output logic        eng_start,
  output logic [7:0]  eng_wdata,
  input  logic        eng_done,
  input  logic [7:0]  eng_rdata
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_t;

  localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
  localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(CS_GAP - 1);

  state_t      state_q, state_d;
  logic [1:0]  rr_ptr_q, rr_ptr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [2:0]  left_q, left_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  byte_ack_q, byte_ack_d;
  logic [2:0]  txn_done_q, txn_done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cs_q, cs_d;
  logic        eng_start_q, eng_start_d;

  logic [2:0]  rot_s;
  logic [1:0]  off_s;
  logic [1:0]  win_idx_s;
  logic [2:0]  win_oh_s;
  logic [1:0]  win_len_s;

  function automatic logic [1:0] wrap3(input logic [2:0] v);
    wrap3 = (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
  endfunction

  // Rotate requests so bit 0 is the requester at rr_ptr, then take the first set bit.
  always_comb begin
    case (rr_ptr_q)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0], req[2], req[1]};
      2'd2:    rot_s = {req[1], req[0], req[2]};
      default: rot_s = req;
    endcase
    if (rot_s[0]) begin
      off_s = 2'd0;
    end else if (rot_s[1]) begin
      off_s = 2'd1;
    end else begin
      off_s = 2'd2;
    end
    win_idx_s = wrap3({1'b0, rr_ptr_q} + {1'b0, off_s});
    win_oh_s  = 3'b001 << win_idx_s;
    win_len_s = req_len[{win_idx_s, 1'b0} +: 2];
  end

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    gnt_d       = gnt_q;
    cs_d        = cs_q;
    rdata_d     = rdata_q;
    byte_ack_d  = 3'b000;
    txn_done_d  = 3'b000;
    eng_start_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 3'b000) begin
          state_d  = SETUP;
          gnt_d    = win_oh_s;
          cs_d     = 1'b0;
          left_d   = {1'b0, win_len_s} + 3'd1;
          rr_ptr_d = wrap3({1'b0, win_idx_s} + 3'd1);
          cnt_d    = SETUP_LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        if (cnt_q == 8'd0) begin
          state_d     = START;
          eng_start_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (eng_done) begin
          rdata_d    = eng_rdata;
          byte_ack_d = gnt_q;
          left_d     = left_q - 3'd1;
          if (left_q > 3'd1) begin
            state_d     = START;
            eng_start_d = 1'b1;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          state_d = WAIT;
        end
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d    = GAP;
          cs_d       = 1'b1;
          gnt_d      = 3'b000;
          txn_done_d = gnt_q;
          cnt_d      = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GAP: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any transaction without txn_done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 2'd0;
      cnt_q       <= 8'd0;
      left_q      <= 3'd0;
      gnt_q       <= 3'b000;
      cs_q        <= 1'b1;
      rdata_q     <= 8'h00;
      byte_ack_q  <= 3'b000;
      txn_done_q  <= 3'b000;
      eng_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      gnt_q       <= gnt_d;
      cs_q        <= cs_d;
      rdata_q     <= rdata_d;
      byte_ack_q  <= byte_ack_d;
      txn_done_q  <= txn_done_d;
      eng_start_q <= eng_start_d;
    end
  end

  // The write byte is muxed live so a byte presented alongside byte_ack reaches the engine.
  assign eng_wdata = {8{eng_start_q}} & (({8{gnt_q[0]}} & req_wdata[7:0])
                                       | ({8{gnt_q[1]}} & req_wdata[15:8])
                                       | ({8{gnt_q[2]}} & req_wdata[23:16]));

  assign gnt       = gnt_q;
  assign cs        = cs_q;
  assign byte_ack  = byte_ack_q;
  assign txn_done  = txn_done_q;
  assign rdata     = rdata_q;
  assign eng_start = eng_start_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: event-scheduled reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_spi_arbiter;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int CS_GAP   = 4;

  logic        clk, rst;
  logic [2:0]  req;
  logic [5:0]  req_len;
  logic [23:0] req_wdata;
  logic [2:0]  gnt, byte_ack, txn_done;
  logic [7:0]  rdata, eng_wdata, eng_rdata;
  logic        cs, eng_start, eng_done;

  int total = 0;
  int bad   = 0;

  bit         fix_lat_en = 1'b0, fix_rd_en = 1'b0, spur_en = 1'b0, force_done = 1'b0;
  int         fix_lat = 1;
  logic [7:0] fix_rd = 8'h00;
  bit         eng_busy;
  int         eng_cnt;

  int         mc = 0, m_owner, m_left, m_start_at, m_rise_at, m_free_at, m_rr;
  bit         m_busy, m_wait;
  logic [2:0] e_gnt, e_ack, e_done;
  logic       e_cs, e_start;
  logic [7:0] e_rdata;

  spi_arbiter #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .req_wdata(req_wdata),
    .gnt(gnt), .byte_ack(byte_ack), .rdata(rdata), .txn_done(txn_done), .cs(cs),
    .eng_start(eng_start), .eng_wdata(eng_wdata), .eng_done(eng_done), .eng_rdata(eng_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int idx_of(input logic [2:0] oh);
    if (oh == 3'b001) return 0;
    if (oh == 3'b010) return 1;
    if (oh == 3'b100) return 2;
    return -1;
  endfunction

  task automatic m_reset();
    m_busy = 1'b0; m_wait = 1'b0; m_rr = 0; m_owner = 0; m_left = 0;
    m_free_at = -1000; m_start_at = -1; m_rise_at = -1;
    e_gnt = 3'b000; e_cs = 1'b1; e_start = 1'b0; e_ack = 3'b000; e_done = 3'b000; e_rdata = 8'h00;
  endtask

  // Model in terms of cycle timestamps: grant, start times, cs rise time, earliest next grant.
  task automatic m_step();
    int c, w;
    mc++;
    c = mc;
    e_start = 1'b0; e_ack = 3'b000; e_done = 3'b000;
    if (!m_busy) begin
      w = -1;
      for (int k = 0; k < 3; k++) begin
        int i;
        i = (m_rr + k) % 3;
        if (w < 0 && req[i]) w = i;
      end
      if (c - 1 >= m_free_at && w >= 0) begin
        m_busy = 1'b1; m_owner = w; m_rr = (w + 1) % 3;
        m_left = int'(req_len[2*w +: 2]) + 1;
        m_start_at = c + CS_SETUP; m_rise_at = -1; m_wait = 1'b0;
        e_gnt = 3'b001 << w; e_cs = 1'b0;
      end
    end else begin
      if (m_wait && eng_done) begin
        e_ack = e_gnt; e_rdata = eng_rdata; m_wait = 1'b0; m_left--;
        if (m_left > 0) m_start_at = c;
        else m_rise_at = c + CS_HOLD;
      end else if (c - 1 == m_start_at) begin
        m_wait = 1'b1;
      end
      if (c == m_start_at) e_start = 1'b1;
      if (c == m_rise_at) begin
        e_cs = 1'b1; e_gnt = 3'b000; e_done = 3'b001 << m_owner;
        m_busy = 1'b0; m_free_at = c + CS_GAP;
      end
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // Byte engine: random or fixed latency after eng_start, optional stray eng_done pulses.
  initial begin
    eng_done = 1'b0; eng_rdata = 8'h00; eng_busy = 1'b0; eng_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      eng_done = 1'b0;
      if (rst) begin
        eng_busy = 1'b0;
      end else if (eng_start) begin
        eng_busy = 1'b1;
        eng_cnt = fix_lat_en ? fix_lat : $urandom_range(1, 3);
      end else if (eng_busy) begin
        eng_cnt--;
        if (eng_cnt == 0) begin
          eng_done = 1'b1; eng_busy = 1'b0;
          eng_rdata = fix_rd_en ? fix_rd : 8'($urandom);
        end
      end else if (force_done) begin
        eng_done = 1'b1; eng_rdata = 8'h5A; force_done = 1'b0;
      end else if (spur_en && $urandom_range(0, 7) == 0) begin
        eng_done = 1'b1; eng_rdata = 8'($urandom);
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("m_gnt", 32'(gnt), 32'(e_gnt));
      check("m_cs", 32'(cs), 32'(e_cs));
      check("m_eng_start", 32'(eng_start), 32'(e_start));
      check("m_byte_ack", 32'(byte_ack), 32'(e_ack));
      check("m_txn_done", 32'(txn_done), 32'(e_done));
      check("m_eng_wdata", 32'(eng_wdata), e_start ? 32'(req_wdata[8*m_owner +: 8]) : 32'd0);
      if (rst || e_ack != 3'b000) check("m_rdata", 32'(rdata), 32'(e_rdata));
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && (gnt !== 3'b000 || cs !== 1'b1); i++) tick();
    check("idle_reached", 32'(gnt), 32'd0);
    repeat (CS_GAP + 2) tick();
  endtask

  logic [7:0] burst_b [4];
  logic [7:0] got [4];
  int         order [4];

  initial begin
    int n, nst, ack_n, ndone, cs_brk, ng, hi, min_hi, nd;
    bit granted, seen_done;
    logic [2:0] prev;
    burst_b[0] = 8'h11; burst_b[1] = 8'h22; burst_b[2] = 8'h33; burst_b[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin got[i] = 8'h00; order[i] = -1; end
    rst = 1'b1; req = 3'b000; req_len = 6'd0; req_wdata = 24'd0;
    repeat (3) tick();
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_eng_wdata", 32'(eng_wdata), 32'd0);
    rst = 1'b0;
    tick();

    // Single byte to requester 1
    fix_rd_en = 1'b1; fix_rd = 8'h3C;
    req = 3'b010; req_len = 6'b000000; req_wdata = 24'h00A500;
    for (int i = 0; i < 50 && cs !== 1'b0; i++) tick();
    check("t1_cs_low", 32'(cs), 32'd0);
    check("t1_gnt", 32'(gnt), 32'b010);
    req = 3'b000;
    n = 0;
    while (eng_start !== 1'b1 && n < 50) begin tick(); n++; end
    check("t1_setup_cycles", n, CS_SETUP);
    check("t1_eng_wdata", 32'(eng_wdata), 32'hA5);
    for (int i = 0; i < 50 && byte_ack === 3'b000; i++) tick();
    check("t1_byte_ack", 32'(byte_ack), 32'b010);
    check("t1_rdata", 32'(rdata), 32'h3C);
    n = 0;
    while (cs !== 1'b1 && n < 50) begin tick(); n++; end
    check("t1_hold_cycles", n, CS_HOLD);
    check("t1_txn_done", 32'(txn_done), 32'b010);
    wait_idle();

    // Four-byte burst from requester 0, data advanced on each byte_ack
    req = 3'b001; req_len = 6'b000011; req_wdata = 24'h000011;
    nst = 0; ack_n = 0; ndone = 0; cs_brk = 0; granted = 1'b0;
    for (int i = 0; i < 300 && ndone == 0; i++) begin
      tick();
      if (byte_ack[0]) begin
        ack_n++;
        if (ack_n < 4) req_wdata[7:0] = burst_b[ack_n];
      end
      #1;
      if (gnt == 3'b001) begin granted = 1'b1; req = 3'b000; end
      if (eng_start) begin
        if (nst < 4) got[nst] = eng_wdata;
        nst++;
      end
      if (txn_done[0]) ndone++;
      else if (granted && cs !== 1'b0) cs_brk++;
    end
    repeat (10) begin tick(); if (txn_done[0]) ndone++; end
    check("t2_starts", nst, 4);
    for (int i = 0; i < 4; i++) check("t2_byte", 32'(got[i]), 32'(burst_b[i]));
    check("t2_cs_continuous", cs_brk, 0);
    check("t2_txn_done_count", ndone, 1);
    wait_idle();

    // Contention after reset: all three requesting
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; req_len = 6'b000000;
    ng = 0; prev = 3'b000; hi = 0; min_hi = 1000; seen_done = 1'b0;
    for (int i = 0; i < 400 && ng < 4; i++) begin
      tick();
      if (gnt != 3'b000 && prev == 3'b000) begin
        if (ng < 4) order[ng] = idx_of(gnt);
        ng++;
        if (seen_done && hi < min_hi) min_hi = hi;
      end
      if (txn_done != 3'b000) seen_done = 1'b1;
      if (cs) hi++; else hi = 0;
      prev = gnt;
    end
    req = 3'b000;
    check("t3_order0", order[0], 0);
    check("t3_order1", order[1], 1);
    check("t3_order2", order[2], 2);
    check("t3_order3", order[3], 0);
    check("t3_gap_ge", 32'(min_hi >= CS_GAP), 32'd1);
    wait_idle();

    // Requester 2 drops req right after grant; two bytes still complete
    req = 3'b100; req_len = 6'b010000;
    for (int i = 0; i < 50 && gnt !== 3'b100; i++) tick();
    check("t4_gnt", 32'(gnt), 32'b100);
    req = 3'b000;
    nst = 0; ndone = 0;
    for (int i = 0; i < 200 && ndone == 0; i++) begin
      tick();
      if (byte_ack[2]) nst++;
      if (txn_done[2]) ndone++;
    end
    check("t4_acks", nst, 2);
    check("t4_txn_done", ndone, 1);
    wait_idle();

    // Reset during the wait of byte 2 of a 4-byte burst
    fix_lat_en = 1'b1; fix_lat = 3;
    req = 3'b001; req_len = 6'b000011;
    nst = 0;
    for (int i = 0; i < 200 && nst < 2; i++) begin tick(); if (eng_start) nst++; end
    check("t5_second_start", nst, 2);
    tick();
    rst = 1'b1;
    #1;
    check("t5_cs_async", 32'(cs), 32'd1);
    check("t5_gnt_async", 32'(gnt), 32'd0);
    req = 3'b000; nd = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) rst = 1'b0;
      tick();
      if (txn_done != 3'b000) nd++;
    end
    check("t5_no_txn_done", nd, 0);
    req = 3'b100; req_len = 6'b000000;
    for (int i = 0; i < 50 && gnt === 3'b000; i++) tick();
    check("t5_regrant", 32'(gnt), 32'b100);
    req = 3'b000; fix_lat_en = 1'b0;
    wait_idle();

    // Stray eng_done in IDLE and in GAP
    force_done = 1'b1;
    tick(); tick();
    check("t6_idle_ack", 32'(byte_ack), 32'd0);
    check("t6_idle_cs", 32'(cs), 32'd1);
    req = 3'b010; req_len = 6'b000000;
    for (int i = 0; i < 100 && txn_done === 3'b000; i++) tick();
    check("t6_txn_done", 32'(txn_done), 32'b010);
    force_done = 1'b1;
    n = 0; nd = 0;
    while (gnt === 3'b000 && n < 50) begin tick(); n++; if (byte_ack != 3'b000) nd++; end
    check("t6_gap_len", n, CS_GAP + 1);
    check("t6_gap_ack", nd, 0);
    req = 3'b000;
    wait_idle();

    // Randomized traffic with stray eng_done and occasional resets
    fix_rd_en = 1'b0; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 5) == 0) req = 3'($urandom);
      if ($urandom_range(0, 3) == 0) req_len = 6'($urandom);
      if ($urandom_range(0, 1) == 0) req_wdata = 24'($urandom);
      if ($urandom_range(0, 599) == 0) begin rst = 1'b1; tick(); rst = 1'b0; end
    end
    req = 3'b000; spur_en = 1'b0;
    repeat (60) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
